// File: rtl/instr_encoder_loader_pkg.sv
// Shared types for the instruction encoder/loader: FSM states, format codes,
// the field bundle and the R/I/J word packer (inverse of the field decoder).
package instr_encoder_loader_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] FMT_R = 2'b00;
   localparam logic [1:0] FMT_I = 2'b01;
   localparam logic [1:0] FMT_J = 2'b10;
   localparam logic [1:0] FMT_X = 2'b11;

   typedef struct packed {
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  sham;
      logic [5:0]  funct;
      logic [15:0] imm16;
      logic [25:0] imm26;
   } fields_t;

   // Illegal formats pack to zero; the caller never pushes them.
   function automatic logic [31:0] pack_word(input logic [1:0] fmt,
                                             input fields_t  f);
      logic [31:0] w;
      case (fmt)
         FMT_R:   w = {f.op, f.rs, f.rt, f.rd, f.sham, f.funct};
         FMT_I:   w = {f.op, f.rs, f.rt, f.imm16};
         FMT_J:   w = {f.op, f.imm26};
         default: w = '0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/instr_encoder_loader_fifo.sv
// instr_fifo: synchronous FIFO of packed words, WIDTH x DEPTH (DEPTH power of 2).
// Ports: clk, rst (sync, active-high), push/wdata, pop/rdata (show-ahead), full, empty.
module instr_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is legal only when a pop frees a slot.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign rdata = mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            wptr <= wptr + AW'(1);
         end
         if (do_pop) begin
            rptr <= rptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs R/I/J instruction fields into 32-bit words, buffers them and streams
// them to the imem write port at consecutive word addresses from base_addr.
// Ports: clk, rst (sync, active-high), start/base_addr (session control),
//  in_valid/in_ready/in_last + fmt/op/rs/rt/rd/sham/funct/imm16/imm26 (field beats),
//  mem_we/mem_addr/mem_wdata (imem write), busy, done (pulse), err (sticky).
module instr_encoder_loader
   import instr_encoder_loader_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_last,
   input  logic [1:0]            fmt,
   input  logic [5:0]            op,
   input  logic [4:0]            rs,
   input  logic [4:0]            rt,
   input  logic [4:0]            rd,
   input  logic [4:0]            sham,
   input  logic [5:0]            funct,
   input  logic [15:0]           imm16,
   input  logic [25:0]           imm26,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   state_t                state;
   state_t                state_nxt;
   fields_t               fields;
   logic [DATA_WIDTH-1:0] packed_word;
   logic [DATA_WIDTH-1:0] head;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  accept;
   logic                  legal;
   logic                  push;
   logic                  pop;

   assign fields = '{op: op, rs: rs, rt: rt, rd: rd, sham: sham,
                     funct: funct, imm16: imm16, imm26: imm26};

   assign packed_word = pack_word(fmt, fields);

   assign in_ready = (state == S_LOAD) && !fifo_full;
   assign accept   = in_valid && in_ready;
   assign legal    = (fmt != FMT_X);
   assign push     = accept && legal;
   assign pop      = !fifo_empty;

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

   instr_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (packed_word),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (start) state_nxt = S_LOAD;
         S_LOAD:  if (accept && in_last) state_nxt = S_DRAIN;
         // The last pop already registered mem_we; it lands with the DONE edge.
         S_DRAIN: if (fifo_empty) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         err       <= 1'b0;
         wr_addr   <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state  <= state_nxt;
         mem_we <= pop;
         if (pop) begin
            mem_addr  <= wr_addr;
            mem_wdata <= head;
            wr_addr   <= wr_addr + ADDR_WIDTH'(4);
         end
         // FIFO is always empty in IDLE, so this never collides with a pop.
         if (state == S_IDLE && start) begin
            wr_addr <= base_addr;
            err     <= 1'b0;
         end
         if (accept && !legal) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: packing, latency, ordering,
// illegal-format drop, address wrap and mid-session reset.
module tb_instr_encoder_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] base_addr = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_last = 1'b0;
   logic [1:0]  fmt = '0;
   logic [5:0]  op = '0;
   logic [4:0]  rs = '0;
   logic [4:0]  rt = '0;
   logic [4:0]  rd = '0;
   logic [4:0]  sham = '0;
   logic [5:0]  funct = '0;
   logic [15:0] imm16 = '0;
   logic [25:0] imm26 = '0;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        busy;
   logic        done;
   logic        err;

   int n_chk = 0;
   int n_fail = 0;
   int done_cnt = 0;

   logic [31:0] log_addr[$];
   logic [31:0] log_data[$];
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];

   instr_encoder_loader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_last   (in_last),
      .fmt       (fmt),
      .op        (op),
      .rs        (rs),
      .rt        (rt),
      .rd        (rd),
      .sham      (sham),
      .funct     (funct),
      .imm16     (imm16),
      .imm26     (imm26),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we) begin
         log_addr.push_back(mem_addr);
         log_data.push_back(mem_wdata);
      end
      if (done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
      exp_addr.push_back(a);
      exp_data.push_back(d);
   endtask

   task automatic new_session(input logic [31:0] b);
      log_addr.delete();
      log_data.delete();
      exp_addr.delete();
      exp_data.delete();
      done_cnt = 0;
      start = 1'b1;
      base_addr = b;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic send_beat(input logic [1:0] f, input logic [5:0] o,
                            input logic [4:0] s, input logic [4:0] t,
                            input logic [4:0] d, input logic [4:0] sh,
                            input logic [5:0] fn, input logic [15:0] i16,
                            input logic [25:0] i26, input logic l);
      bit ok = 0;
      fmt = f; op = o; rs = s; rt = t; rd = d; sham = sh;
      funct = fn; imm16 = i16; imm26 = i26;
      in_last = l;
      in_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (ok) begin
         @(posedge clk);
         #1;
      end else begin
         chk("accept_timeout", 0, 1);
      end
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit seen = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
      end
      chk({tag, "_done_seen"}, seen, 1);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_idle"}, busy, 0);
      chk({tag, "_done_cnt"}, done_cnt, 1);
   endtask

   task automatic check_log(input string tag);
      chk({tag, "_nwr"}, log_addr.size(), exp_addr.size());
      for (int i = 0; i < exp_addr.size(); i++) begin
         if (i < log_addr.size()) begin
            chk($sformatf("%s_addr%0d", tag, i), log_addr[i], exp_addr[i]);
            chk($sformatf("%s_data%0d", tag, i), log_data[i], exp_data[i]);
         end
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      @(posedge clk);
      #1;

      // 1: R-pack and first-word latency
      new_session(32'h0);
      chk("t1_busy", busy, 1);
      expect_wr(32'h0, 32'h012A4020);
      send_beat(2'b00, 6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h0, 26'h0, 1);
      @(negedge clk);
      chk("t1_lat_early", mem_we, 0);
      @(negedge clk);
      chk("t1_lat_we", mem_we, 1);
      wait_done("t1");
      check_log("t1");
      chk("t1_err", err, 0);

      // 2: I then J
      @(posedge clk);
      #1;
      new_session(32'h400);
      expect_wr(32'h400, 32'h20080005);
      expect_wr(32'h404, 32'h08100000);
      send_beat(2'b01, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0, 0);
      send_beat(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0100000, 1);
      wait_done("t2");
      check_log("t2");

      // 3: eight back-to-back beats
      @(posedge clk);
      #1;
      new_session(32'h1000);
      for (int i = 0; i < 8; i++) begin
         expect_wr(32'h1000 + 32'(4 * i), 32'h20010000 | 32'(i));
      end
      for (int i = 0; i < 8; i++) begin
         send_beat(2'b01, 6'h08, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0,
                   16'(i), 26'h0, (i == 7));
      end
      wait_done("t3");
      check_log("t3");

      // 4: illegal beat dropped, address not consumed, err sticky
      @(posedge clk);
      #1;
      new_session(32'h100);
      expect_wr(32'h100, 32'h00221821);
      expect_wr(32'h104, 32'h20080005);
      send_beat(2'b00, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0, 26'h0, 0);
      send_beat(2'b11, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 0);
      send_beat(2'b01, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0, 1);
      wait_done("t4");
      check_log("t4");
      chk("t4_err", err, 1);
      repeat (3) @(negedge clk);
      chk("t4_err_hold", err, 1);

      // 4b: session of only an illegal beat
      @(posedge clk);
      #1;
      new_session(32'h300);
      chk("t4b_err_clr", err, 0);
      send_beat(2'b11, 6'h01, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1);
      wait_done("t4b");
      check_log("t4b");
      chk("t4b_err", err, 1);

      // 5: address wrap
      @(posedge clk);
      #1;
      new_session(32'hFFFFFFFC);
      chk("t5_err_clr", err, 0);
      expect_wr(32'hFFFFFFFC, 32'h08000001);
      expect_wr(32'h00000000, 32'h08000002);
      send_beat(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h1, 0);
      send_beat(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h2, 1);
      wait_done("t5");
      check_log("t5");

      // 6: reset in the middle of LOAD
      @(posedge clk);
      #1;
      new_session(32'h800);
      for (int i = 0; i < 3; i++) begin
         send_beat(2'b10, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0,
                   26'h3000 + 26'(i), 0);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t6_rst_we", mem_we, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_ready", in_ready, 0);
      @(posedge clk);
      #1;
      new_session(32'h200);
      expect_wr(32'h200, 32'h0C000077);
      send_beat(2'b10, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h77, 1);
      wait_done("t6");
      check_log("t6");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
